// File: rtl/input_port.sv
// input_port: wishbone slave bringing synchronized, debounced board inputs onto the data bus
// with sticky rising-edge flags (write-1-to-clear) and a registered level interrupt.
module input_port #(
    parameter int WIDTH           = 13,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    input  logic [3:0]       sel_i,
    input  logic             we_i,
    input  logic             stb_i,
    input  logic             cyc_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1, s2, deb, deb_q, edge_r, irq_en;
    logic [WIDTH-1:0] edge_nx, irq_en_nx, clr;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [31:0]      mask, rd;
    logic             req;
    logic             unused_adr;

    assign unused_adr = ^{adr_i[31:4], adr_i[1:0]};
    assign req        = cyc_i & stb_i & ~ack_o;
    assign mask       = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

    always_comb begin
        rd = adr_i[3:2] == 2'd0 ? 32'(deb) :
             adr_i[3:2] == 2'd1 ? 32'(edge_r) :
             adr_i[3:2] == 2'd2 ? 32'(irq_en) : 32'(s2);
        clr = (req && we_i && adr_i[3:2] == 2'd1) ? WIDTH'(dat_i & mask) : '0;
        irq_en_nx = (req && we_i && adr_i[3:2] == 2'd2) ?
                    WIDTH'((32'(irq_en) & ~mask) | (dat_i & mask)) : irq_en;
        // a new rising edge beats a same-cycle clear
        edge_nx = (edge_r & ~clr) | (deb & ~deb_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1    <= pins;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            edge_r <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            ack_o  <= req;
            if (req && !we_i) dat_o <= rd;
            edge_r <= edge_nx;
            irq_en <= irq_en_nx;
            irq    <= |(edge_nx & irq_en_nx);
        end
    end
endmodule

// File: tb/tb_input_port.sv
// tb_input_port: randomized bench for input_port against a sliding-window debounce reference model.
module tb_input_port;
    localparam int W = 13;
    localparam int D = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  pins = '0;
    logic [31:0]   adr_i = '0, dat_i = '0;
    logic [3:0]    sel_i = '0;
    logic          we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic [31:0]   dat_o;
    logic          ack_o, irq;
    logic          mon_en = 1'b0;
    int            checks = 0, failures = 0;

    input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .pins(pins), .adr_i(adr_i), .dat_i(dat_i),
        .sel_i(sel_i), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i),
        .dat_o(dat_o), .ack_o(ack_o), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: pin samples per edge; a bit flips once the last D synchronized samples all disagree
    logic [W-1:0] ph[$];
    logic [W-1:0] deb_m, debq_m, edge_m, en_m;
    logic         ack_m, irq_m;
    logic [31:0]  dat_m;

    always @(posedge clock or negedge reset) begin : model
        logic [W-1:0] nd, clr, ne, nen;
        logic [31:0]  m, rv;
        bit           all;
        if (!reset) begin
            ph = {};
            for (int k = 0; k < D + 2; k++) ph.push_front('0);
            deb_m = '0; debq_m = '0; edge_m = '0; en_m = '0;
            ack_m = 1'b0; irq_m = 1'b0; dat_m = '0;
        end else begin
            ph.push_front(pins);
            if (ph.size() > D + 2) void'(ph.pop_back());
            nd = deb_m;
            for (int i = 0; i < W; i++) begin
                all = 1;
                for (int k = 2; k < D + 2; k++) if (ph[k][i] == deb_m[i]) all = 0;
                if (all) nd[i] = ~deb_m[i];
            end
            for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel_i[b]}};
            case (adr_i[3:2])
                2'd0: rv = 32'(deb_m);
                2'd1: rv = 32'(edge_m);
                2'd2: rv = 32'(en_m);
                default: rv = 32'(ph[2]);
            endcase
            clr = '0;
            nen = en_m;
            if (cyc_i && stb_i && !ack_m) begin
                if (!we_i) dat_m = rv;
                else if (adr_i[3:2] == 2'd1) clr = W'(dat_i & m);
                else if (adr_i[3:2] == 2'd2) nen = W'((32'(en_m) & ~m) | (dat_i & m));
            end
            ne     = (edge_m & ~clr) | (deb_m & ~debq_m);
            ack_m  = cyc_i & stb_i & ~ack_m;
            irq_m  = |(ne & nen);
            debq_m = deb_m;
            deb_m  = nd;
            edge_m = ne;
            en_m   = nen;
        end
    end

    always @(negedge clock) begin
        if (reset && mon_en) begin
            check("ack", 32'(ack_o), 32'(ack_m));
            check("irq", 32'(irq), 32'(irq_m));
            check("dat", dat_o, dat_m);
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        int n = 0;
        adr_i = $urandom();
        adr_i[3:2] = a;
        we_i = w; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!ack_o && n < 4);
        check("ack_seen", 32'(ack_o), 32'd1);
        q = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [31:0] q;
        int n;
        idle(3);
        reset = 1'b1;
        mon_en = 1'b1;
        idle(5);
        check("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus(1'b0, 2'(a), '0, '0, q);
            check($sformatf("rst_rd%0d", a), q, 32'd0);
        end
        pins[0] = 1'b1;
        repeat (14) bus(1'b0, 2'd0, '0, '0, q);
        check("data0", 32'(q[0]), 32'd1);
        bus(1'b0, 2'd1, '0, '0, q);
        check("edge0", q, 32'h1);
        bus(1'b1, 2'd1, 32'h1, 4'hF, q);
        pins[3] = 1'b1;
        repeat (5) bus(1'b0, 2'd3, '0, '0, q);
        pins[3] = 1'b0;
        repeat (15) bus(1'b0, 2'd3, '0, '0, q);
        bus(1'b0, 2'd0, '0, '0, q);
        check("glitch_data3", 32'(q[3]), 32'd0);
        bus(1'b0, 2'd1, '0, '0, q);
        check("glitch_edge3", 32'(q[3]), 32'd0);
        bus(1'b1, 2'd2, 32'h4, 4'hF, q);
        pins[2] = 1'b1;
        n = 0;
        while (!irq && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("irq_set", 32'(irq), 32'd1);
        bus(1'b1, 2'd1, 32'h4, 4'hF, q);
        check("irq_clr", 32'(irq), 32'd0);
        pins[1] = 1'b1;
        idle(25);
        bus(1'b1, 2'd1, 32'h2, 4'h0, q);
        bus(1'b0, 2'd1, '0, '0, q);
        check("sel0_keep", 32'(q[1]), 32'd1);
        pins[1] = 1'b0;
        idle(25);
        bus(1'b1, 2'd1, 32'h2, 4'hF, q);
        pins[1] = 1'b1;
        idle(17);
        bus(1'b1, 2'd1, 32'h2, 4'hF, q);
        bus(1'b0, 2'd1, '0, '0, q);
        check("set_wins", 32'(q[1]), 32'd1);
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) == 0) pins[$urandom_range(0, W - 1)] ^= 1'b1;
            bus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                4'($urandom_range(0, 15)), q);
            idle($urandom_range(0, 5));
        end
        pins = '0;
        idle(40);
        adr_i = '0; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        #1 check("burst0", 32'(ack_o), 32'd0);
        for (int k = 1; k < 6; k++) begin
            @(negedge clock);
            check($sformatf("burst%0d", k), 32'(ack_o), 32'(k % 2));
        end
        reset = 1'b0;
        #1;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq2", 32'(irq), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
        for (int a = 0; a < 4; a++) begin
            bus(1'b0, 2'(a), '0, '0, q);
            check($sformatf("rst2_rd%0d", a), q, 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
